// File: rtl/hazard_if.sv
// hazard_if: ID-stage operand, producer-stage and mult/div signals between the pipeline and hazard_unit.
interface hazard_if #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_W          = 5
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  logic                            id_valid;
  logic [REG_W-1:0]                id_rs;
  logic [REG_W-1:0]                id_rt;
  logic                            id_use_rs;
  logic                            id_use_rt;
  logic                            id_is_branch;
  logic [1:0]                      id_md_op;
  logic [NUM_FWD_STAGES-1:0]       st_wen;
  logic [NUM_FWD_STAGES*REG_W-1:0] st_waddr;
  logic [NUM_FWD_STAGES-1:0]       st_is_load;
  logic                            ex_flush;
  logic [SEL_W-1:0]                fwd_a_sel;
  logic [SEL_W-1:0]                fwd_b_sel;
  logic                            stall_id;
  logic                            md_busy;
  logic                            md_done;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_md_op,
           st_wen, st_waddr, st_is_load, ex_flush,
    input  fwd_a_sel, fwd_b_sel, stall_id, md_busy, md_done
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_is_branch, id_md_op,
           st_wen, st_waddr, st_is_load, ex_flush,
    output fwd_a_sel, fwd_b_sel, stall_id, md_busy, md_done
  );
endinterface

// File: rtl/hazard_unit.sv
// hazard_unit: operand forwarding select, load-use/branch stalls and mult/div busy tracking.
module hazard_unit #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int REG_W          = 5,
  parameter int MUL_LAT        = 2,
  parameter int DIV_LAT        = 33,
  parameter int CNT_W          = 6
) (
  input  logic clk,
  input  logic resetn,
  hazard_if.slave hz
);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_hit, b_hit, a_ld, b_ld;
  logic [SEL_W-1:0] a_sel, b_sel;
  logic             load_use, branch_haz, md_haz, md_issue;
  // Scan oldest to youngest so the lowest-index match overwrites older ones.
  always_comb begin
    a_hit = 1'b0;
    b_hit = 1'b0;
    a_ld  = 1'b0;
    b_ld  = 1'b0;
    a_sel = '0;
    b_sel = '0;
    for (int i = NUM_FWD_STAGES - 1; i >= 0; i--) begin
      if (hz.st_wen[i] && hz.st_waddr[i*REG_W +: REG_W] != '0 && hz.st_waddr[i*REG_W +: REG_W] == hz.id_rs) begin
        a_hit = hz.id_use_rs;
        a_ld  = hz.st_is_load[i];
        a_sel = SEL_W'(i + 1);
      end
      if (hz.st_wen[i] && hz.st_waddr[i*REG_W +: REG_W] != '0 && hz.st_waddr[i*REG_W +: REG_W] == hz.id_rt) begin
        b_hit = hz.id_use_rt;
        b_ld  = hz.st_is_load[i];
        b_sel = SEL_W'(i + 1);
      end
    end
  end
  assign hz.fwd_a_sel = (a_hit && !a_ld) ? a_sel : '0;
  assign hz.fwd_b_sel = (b_hit && !b_ld) ? b_sel : '0;
  assign load_use   = (a_hit && a_ld) || (b_hit && b_ld);
  assign branch_haz = hz.id_is_branch && ((a_hit && a_sel == SEL_W'(1)) || (b_hit && b_sel == SEL_W'(1)));
  assign md_haz     = state_q == BUSY && hz.id_md_op != 2'b00;
  assign hz.stall_id = hz.id_valid && (load_use || branch_haz || md_haz);
  assign md_issue   = hz.id_valid && (hz.id_md_op == 2'b01 || hz.id_md_op == 2'b10) &&
                      !load_use && !branch_haz && !hz.ex_flush;
  assign hz.md_busy = state_q == BUSY;
  // A flush in the final busy cycle suppresses the completion pulse.
  assign hz.md_done = state_q == BUSY && cnt_q == '0 && !hz.ex_flush;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      state_d = md_issue ? BUSY : IDLE;
      cnt_d   = md_issue ? (hz.id_md_op == 2'b01 ? CNT_W'(MUL_LAT - 1) : CNT_W'(DIV_LAT - 1)) : cnt_q;
    end else begin
      state_d = (hz.ex_flush || cnt_q == '0) ? IDLE : BUSY;
      cnt_d   = (hz.ex_flush || cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector bench for hazard_unit forwarding, stalls and mult/div tracking.
module tb_hazard_unit;
  logic clk;
  logic resetn;
  int   errs;
  int   checks;
  hazard_if #(.NUM_FWD_STAGES(2), .REG_W(5)) hz ();
  hazard_unit #(.NUM_FWD_STAGES(2), .REG_W(5), .MUL_LAT(2), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk),
    .resetn(resetn),
    .hz(hz)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs();
    hz.id_valid = 1'b0;
    hz.id_rs = '0;
    hz.id_rt = '0;
    hz.id_use_rs = 1'b0;
    hz.id_use_rt = 1'b0;
    hz.id_is_branch = 1'b0;
    hz.id_md_op = 2'b00;
    hz.st_wen = '0;
    hz.st_waddr = '0;
    hz.st_is_load = '0;
    hz.ex_flush = 1'b0;
  endtask
  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    #2;
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", hz.md_busy); end
    checks++; if (hz.md_done !== 1'b0) begin errs++; $display("FAIL reset_done got=%b exp=0", hz.md_done); end
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL reset_stall got=%b exp=0", hz.stall_id); end
    checks++; if (hz.fwd_a_sel !== 2'd0) begin errs++; $display("FAIL reset_fwd_a got=%0d exp=0", hz.fwd_a_sel); end
    tick();
    resetn = 1'b1;
    tick();
  endtask
  task automatic test_fwd();
    clear_inputs();
    hz.id_valid = 1'b1;
    hz.st_wen = 2'b11;
    hz.st_waddr = {5'd8, 5'd8};
    hz.id_rs = 5'd8;
    hz.id_use_rs = 1'b1;
    hz.id_rt = 5'd8;
    #1;
    checks++; if (hz.fwd_a_sel !== 2'd1) begin errs++; $display("FAIL fwd_exe_wins got=%0d exp=1", hz.fwd_a_sel); end
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL fwd_exe_stall got=%b exp=0", hz.stall_id); end
    checks++; if (hz.fwd_b_sel !== 2'd0) begin errs++; $display("FAIL fwd_unused_rt got=%0d exp=0", hz.fwd_b_sel); end
    hz.st_wen = 2'b10;
    hz.id_valid = 1'b0;
    #1;
    checks++; if (hz.fwd_a_sel !== 2'd2) begin errs++; $display("FAIL fwd_mem_invalid got=%0d exp=2", hz.fwd_a_sel); end
    hz.st_waddr = {5'd8, 5'd3};
    hz.st_wen = 2'b11;
    hz.id_rt = 5'd3;
    hz.id_use_rt = 1'b1;
    hz.id_valid = 1'b1;
    #1;
    checks++; if (hz.fwd_b_sel !== 2'd1) begin errs++; $display("FAIL fwd_b_exe got=%0d exp=1", hz.fwd_b_sel); end
    checks++; if (hz.fwd_a_sel !== 2'd2) begin errs++; $display("FAIL fwd_a_mem got=%0d exp=2", hz.fwd_a_sel); end
  endtask
  task automatic test_load_use();
    clear_inputs();
    hz.id_valid = 1'b1;
    hz.st_wen = 2'b01;
    hz.st_waddr = {5'd0, 5'd9};
    hz.st_is_load = 2'b01;
    hz.id_rt = 5'd9;
    hz.id_use_rt = 1'b1;
    hz.id_md_op = 2'b01;
    #1;
    checks++; if (hz.stall_id !== 1'b1) begin errs++; $display("FAIL load_use_stall got=%b exp=1", hz.stall_id); end
    checks++; if (hz.fwd_b_sel !== 2'd0) begin errs++; $display("FAIL load_use_sel got=%0d exp=0", hz.fwd_b_sel); end
    tick();
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL load_use_blocks_issue got=%b exp=0", hz.md_busy); end
    hz.id_md_op = 2'b00;
    hz.st_wen = 2'b10;
    hz.st_waddr = {5'd9, 5'd0};
    hz.st_is_load = 2'b00;
    #1;
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL load_moved_stall got=%b exp=0", hz.stall_id); end
    checks++; if (hz.fwd_b_sel !== 2'd2) begin errs++; $display("FAIL load_moved_sel got=%0d exp=2", hz.fwd_b_sel); end
    hz.st_wen = 2'b11;
    hz.st_waddr = {5'd9, 5'd9};
    hz.st_is_load = 2'b10;
    #1;
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL older_load_ignored got=%b exp=0", hz.stall_id); end
    checks++; if (hz.fwd_b_sel !== 2'd1) begin errs++; $display("FAIL older_load_sel got=%0d exp=1", hz.fwd_b_sel); end
  endtask
  task automatic test_zero_branch();
    clear_inputs();
    hz.id_valid = 1'b1;
    hz.st_wen = 2'b01;
    hz.st_waddr = {5'd0, 5'd0};
    hz.st_is_load = 2'b01;
    hz.id_use_rs = 1'b1;
    hz.id_is_branch = 1'b1;
    #1;
    checks++; if (hz.fwd_a_sel !== 2'd0) begin errs++; $display("FAIL zero_sel got=%0d exp=0", hz.fwd_a_sel); end
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL zero_stall got=%b exp=0", hz.stall_id); end
    hz.st_is_load = 2'b00;
    hz.st_waddr = {5'd0, 5'd4};
    hz.id_rs = 5'd4;
    #1;
    checks++; if (hz.stall_id !== 1'b1) begin errs++; $display("FAIL branch_exe_stall got=%b exp=1", hz.stall_id); end
    hz.id_valid = 1'b0;
    #1;
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL branch_invalid got=%b exp=0", hz.stall_id); end
    hz.id_valid = 1'b1;
    hz.st_wen = 2'b10;
    hz.st_waddr = {5'd4, 5'd0};
    #1;
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL branch_mem_stall got=%b exp=0", hz.stall_id); end
    checks++; if (hz.fwd_a_sel !== 2'd2) begin errs++; $display("FAIL branch_mem_sel got=%0d exp=2", hz.fwd_a_sel); end
  endtask
  task automatic test_div_mflo();
    clear_inputs();
    tick();
    hz.id_valid = 1'b1;
    hz.id_md_op = 2'b10;
    #1;
    checks++; if (hz.stall_id !== 1'b0 || hz.md_busy !== 1'b0) begin errs++; $display("FAIL div_issue got stall=%b busy=%b exp 0 0", hz.stall_id, hz.md_busy); end
    for (int k = 1; k <= 33; k++) begin
      tick();
      hz.id_valid = (k >= 5);
      hz.id_md_op = (k >= 5) ? 2'b11 : 2'b00;
      #1;
      checks++; if (hz.md_busy !== 1'b1) begin errs++; $display("FAIL div_busy k=%0d got=%b exp=1", k, hz.md_busy); end
      checks++; if (hz.md_done !== (k == 33)) begin errs++; $display("FAIL div_done k=%0d got=%b exp=%b", k, hz.md_done, k == 33); end
      checks++; if (hz.stall_id !== (k >= 5)) begin errs++; $display("FAIL mflo_stall k=%0d got=%b exp=%b", k, hz.stall_id, k >= 5); end
    end
    tick();
    checks++; if (hz.md_busy !== 1'b0 || hz.md_done !== 1'b0) begin errs++; $display("FAIL div_end got busy=%b done=%b exp 0 0", hz.md_busy, hz.md_done); end
    checks++; if (hz.stall_id !== 1'b0) begin errs++; $display("FAIL mflo_release got=%b exp=0", hz.stall_id); end
  endtask
  task automatic test_back_to_back();
    clear_inputs();
    tick();
    hz.id_valid = 1'b1;
    hz.id_md_op = 2'b01;
    tick();
    checks++; if (hz.md_busy !== 1'b1 || hz.md_done !== 1'b0) begin errs++; $display("FAIL mult_t1 got busy=%b done=%b exp 1 0", hz.md_busy, hz.md_done); end
    checks++; if (hz.stall_id !== 1'b1) begin errs++; $display("FAIL mult_second_stall got=%b exp=1", hz.stall_id); end
    tick();
    checks++; if (hz.md_busy !== 1'b1 || hz.md_done !== 1'b1) begin errs++; $display("FAIL mult_t2 got busy=%b done=%b exp 1 1", hz.md_busy, hz.md_done); end
    tick();
    checks++; if (hz.md_busy !== 1'b0 || hz.stall_id !== 1'b0) begin errs++; $display("FAIL mult_t3 got busy=%b stall=%b exp 0 0", hz.md_busy, hz.stall_id); end
    tick();
    checks++; if (hz.md_busy !== 1'b1) begin errs++; $display("FAIL mult_reissue got=%b exp=1", hz.md_busy); end
    hz.id_valid = 1'b0;
    tick();
    hz.ex_flush = 1'b1;
    #1;
    checks++; if (hz.md_done !== 1'b0) begin errs++; $display("FAIL flush_beats_done got=%b exp=0", hz.md_done); end
    tick();
    hz.ex_flush = 1'b0;
    #1;
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL flush_final_idle got=%b exp=0", hz.md_busy); end
  endtask
  task automatic test_flush();
    clear_inputs();
    tick();
    hz.id_valid = 1'b1;
    hz.id_md_op = 2'b01;
    tick();
    hz.id_valid = 1'b0;
    hz.id_md_op = 2'b00;
    hz.ex_flush = 1'b1;
    #1;
    checks++; if (hz.md_done !== 1'b0) begin errs++; $display("FAIL flush_t1_done got=%b exp=0", hz.md_done); end
    tick();
    hz.ex_flush = 1'b0;
    #1;
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL flush_t2_busy got=%b exp=0", hz.md_busy); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (hz.md_done !== 1'b0 || hz.md_busy !== 1'b0) begin errs++; $display("FAIL flush_after k=%0d got busy=%b done=%b exp 0 0", k, hz.md_busy, hz.md_done); end
    end
    hz.id_valid = 1'b1;
    hz.id_md_op = 2'b10;
    hz.ex_flush = 1'b1;
    tick();
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL flush_blocks_issue got=%b exp=0", hz.md_busy); end
  endtask
  task automatic test_reset_mid();
    clear_inputs();
    tick();
    hz.id_valid = 1'b1;
    hz.id_md_op = 2'b10;
    tick();
    clear_inputs();
    for (int k = 0; k < 10; k++) tick();
    checks++; if (hz.md_busy !== 1'b1) begin errs++; $display("FAIL mid_busy got=%b exp=1", hz.md_busy); end
    resetn = 1'b0;
    #1;
    checks++; if (hz.md_busy !== 1'b0) begin errs++; $display("FAIL async_reset_busy got=%b exp=0", hz.md_busy); end
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++; if (hz.md_done !== 1'b0 || hz.md_busy !== 1'b0) begin errs++; $display("FAIL post_reset k=%0d got busy=%b done=%b exp 0 0", k, hz.md_busy, hz.md_done); end
    end
  endtask
  initial begin
    errs = 0;
    checks = 0;
    test_reset();
    test_fwd();
    test_load_use();
    test_zero_branch();
    test_div_mflo();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Parametrised forwarding and stall unit for the in-order MIPS pipeline; sits beside the ID-stage decoder.
- For each source operand (rs, rt), selects the youngest in-flight producer among NUM_FWD_STAGES post-ID stages, or the register file.
- Detects load-use and branch-in-ID hazards.
- Owns a small FSM that tracks the multi-cycle mult/div unit and stalls dependent HI/LO traffic.

Parameters:
- NUM_FWD_STAGES, 2, number of producer stages after ID (index 0 = EXE, 1 = MEM, ...); must be >= 1.
- REG_W, 5, register address width.
- MUL_LAT, 2, mult/multu busy cycles; must be >= 1.
- DIV_LAT, 33, div/divu busy cycles; must be >= 1.
- CNT_W, 6, busy-counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT).
- SEL_W (derived localparam) = $clog2(NUM_FWD_STAGES+1).

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a valid instruction
- id_rs  in  REG_W  source A register
- id_rt  in  REG_W  source B register
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_is_branch  in  1  branch/jr that resolves operands in ID
- id_md_op  in  2  00 none, 01 mult/multu, 10 div/divu, 11 HI/LO access (mfhi/mflo/mthi/mtlo)
- st_wen  in  NUM_FWD_STAGES  per-stage regfile write enable
- st_waddr  in  NUM_FWD_STAGES*REG_W  per-stage destination; stage i at bits [i*REG_W +: REG_W]
- st_is_load  in  NUM_FWD_STAGES  stage i result not yet available (load before data return)
- ex_flush  in  1  exception/flush; kills any pending mult/div
- fwd_a_sel  out  SEL_W  rs source: 0 = regfile, k = stage k-1
- fwd_b_sel  out  SEL_W  rt source, same encoding
- stall_id  out  1  hold PC/IF/ID and insert a bubble into EXE
- md_busy  out  1  mult/div unit occupied
- md_done  out  1  one-cycle pulse when the mult/div result is written to HI/LO

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, resetn.
- Match rule: stage i matches source s when st_wen[i], st_waddr_i != 0 and st_waddr_i == s.
- Youngest wins: the lowest-index matching stage is the only candidate; older matches are ignored.
- Forward select: if the source is used and the youngest match is not a load, fwd_x_sel = i+1. Otherwise fwd_x_sel = 0.
- Register $0 never forwards and never stalls.
- load_use: a used source's youngest match has st_is_load set.
- branch_haz: id_is_branch and a used source matches stage 0, regardless of load. There is no EXE-to-ID forwarding path.
- md_haz: state == BUSY and id_md_op != 00.
- stall_id = id_valid & (load_use | branch_haz | md_haz). Purely combinational, zero latency.
- Forward selects are combinational and are computed even when id_valid = 0.
- FSM states: IDLE, BUSY. A CNT_W-bit down-counter cnt.
- IDLE -> BUSY when all hold: id_valid, id_md_op is 01 or 10, no load_use/branch_haz, !ex_flush.
  - cnt loads MUL_LAT-1 (mult) or DIV_LAT-1 (div).
- BUSY with cnt != 0: cnt decrements.
- BUSY with cnt == 0: md_done = 1 that cycle, next state IDLE.
- ex_flush in BUSY: next state IDLE, cnt = 0, no md_done. ex_flush has priority over completion in the same cycle.
- Issue at cycle T gives md_busy high T+1 .. T+LAT and md_done at T+LAT.
- md_haz still applies in the md_done cycle (conservative); a HI/LO access proceeds the following cycle.
- md_busy = (state == BUSY); md_done is registered-state derived with no glitch outside BUSY.
- Reset (asynchronous, any time, including mid-divide): state IDLE, cnt 0, md_busy 0, md_done 0. No completion pulse after resetn deasserts.
- No other internal state.

Test Plan:
- Forwarding from EXE: st_wen = 2'b11, st_waddr = {5'd8, 5'd8}, id_rs = 8, id_use_rs = 1 -> fwd_a_sel = 1 (EXE beats MEM), stall_id = 0.
- Load-use: st_wen[0] = 1, st_waddr_0 = 9, st_is_load[0] = 1, id_rt = 9, id_use_rt = 1, id_valid = 1 -> stall_id = 1, fwd_b_sel = 0. Next cycle the load moves to stage 1 with st_is_load[1] = 0 -> stall_id = 0, fwd_b_sel = 2.
- $0 and branch: id_rs = 0 matching stage 0 with st_waddr_0 = 0 -> sel 0, no stall. Branch with id_rs = 4 and EXE writing r4 -> stall_id = 1.
- Divide then mflo: issue div at T -> md_busy T+1..T+33, md_done only at T+33. mflo in ID at T+5 stalls through T+33 and is released at T+34.
- Flush and reset: mult issued at T, ex_flush at T+1 -> md_busy 0 at T+2, md_done never pulses. Div busy with resetn pulled low mid-count -> md_busy = 0 immediately, no md_done after release.
